// File: rtl/shift_scheduler.sv
// Round-robin scheduler that time-shares one left shifter among NREQ requesters
// and returns each ID-tagged result over a valid/ready handshake.

module left_shifter #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   sh,
  output logic [WIDTH-1:0] y
);

  // Saturate to zero once every operand bit has been pushed out.
  function automatic logic [WIDTH-1:0] shl_sat(input logic [WIDTH-1:0] v,
                                                input logic [SHW-1:0]   s);
    if (int'(s) >= WIDTH) return '0;
    return v << s;
  endfunction

  assign y = shl_sat(a, sh);

endmodule

module shift_scheduler #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int SHW   = 4,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ*SHW-1:0]  req_shift,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WIDTH-1:0]     resp_data,
  output logic [IDW-1:0]       resp_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant;
  logic             any_req;
  logic [WIDTH-1:0] op_q;
  logic [SHW-1:0]   sh_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] shift_res;

  // Scan from rr_ptr upward, wrapping at NREQ (which need not be a power of two).
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;
    grant   = '0;
    any_req = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      cand = sum[IDW-1:0];
      if (!any_req && req_valid[cand]) begin
        any_req = 1'b1;
        grant   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && any_req) req_ready[grant] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  left_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shl (
    .a  (op_q),
    .sh (sh_q),
    .y  (shift_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_q      <= '0;
      sh_q      <= '0;
      id_q      <= '0;
      resp_data <= '0;
      resp_id   <= '0;
    end else begin
      state <= state_nx;
      // Capture stage: latch the grantee's operand as the grant is issued
      if (state == IDLE && any_req) begin
        op_q   <= req_data[int'(grant)*WIDTH +: WIDTH];
        sh_q   <= req_shift[int'(grant)*SHW +: SHW];
        id_q   <= grant;
        rr_ptr <= (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
      end
      // Execute stage: register the shifter output for the response
      if (state == EXEC) begin
        resp_data <= shift_res;
        resp_id   <= id_q;
      end
    end
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_shift_scheduler.sv
// Directed and randomized bench for shift_scheduler, scored against a
// transaction-level model of grants, latency and shifted results.

module tb_shift_scheduler;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int S  = 4;
  localparam int I  = 2;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data;
  logic [N*S-1:0] req_shift;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_data;
  logic [I-1:0]   resp_id;
  logic           busy;
  logic [W-1:0]   dat [N];
  logic [S-1:0]   shf [N];

  for (genvar g = 0; g < N; g++) begin : pk
    assign req_data[g*W +: W]  = dat[g];
    assign req_shift[g*S +: S] = shf[g];
  end

  shift_scheduler #(.WIDTH(W), .NREQ(N), .SHW(S), .IDW(I)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_shift(req_shift),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
  );

  logic [N-1:0]    v8, rdy8;
  logic [N*W8-1:0] data8;
  logic [N*S-1:0]  sh8;
  logic            rv8, rr8, b8;
  logic [W8-1:0]   d8;
  logic [I-1:0]    id8;

  shift_scheduler #(.WIDTH(W8), .NREQ(N), .SHW(S), .IDW(I)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v8), .req_ready(rdy8),
    .req_data(data8), .req_shift(sh8),
    .resp_valid(rv8), .resp_ready(rr8),
    .resp_data(d8), .resp_id(id8), .busy(b8)
  );

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] d;
    int           id;
  } exp_t;

  exp_t         exp_q[$];
  int           glog[$];
  int           gcyc[$];
  int           m_rr, outstanding, age, cyc, hs_cyc;
  bit           cont;
  logic [W-1:0] last_resp;
  logic [I-1:0] last_id;
  logic [N-1:0] last_rdy;
  logic         last_busy, last_rv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // op * 2^s reduced modulo 2^W; anything shifted by W or more is zero
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input int s);
    if (s >= W) return '0;
    return W'((longint'(v) * (longint'(1) << s)) % (longint'(1) << W));
  endfunction

  // One clock of observation against the model, then the requester reaction.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    int  g;
    bit  exp_v, hs;
    @(negedge clk);
    exp_rdy = '0;
    g = -1;
    if (outstanding == 0)
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (g < 0 && req_valid[c]) g = c;
      end
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_v = (outstanding != 0) && (age >= 1);
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, outstanding != 0);
    chk("resp_valid", resp_valid, exp_v);
    if (exp_v) begin
      chk("resp_data", resp_data, exp_q[0].d);
      chk("resp_id", resp_id, exp_q[0].id);
    end
    last_rdy  = req_ready;
    last_busy = busy;
    last_rv   = resp_valid;
    if (resp_valid) begin
      last_resp = resp_data;
      last_id   = resp_id;
    end
    hs = exp_v && resp_ready;
    @(posedge clk);
    if (hs) begin
      void'(exp_q.pop_front());
      outstanding--;
      hs_cyc = cyc;
    end
    if (outstanding > 0) age++;
    if (g >= 0) begin
      exp_q.push_back('{d: ref_shift(dat[g], int'(shf[g])), id: g});
      outstanding++;
      age  = 0;
      m_rr = (g + 1) % N;
      glog.push_back(g);
      gcyc.push_back(cyc);
    end
    cyc++;
    #1;
    if (g >= 0) begin
      if (cont) begin
        dat[g] = W'($urandom);
        shf[g] = S'($urandom);
      end else begin
        req_valid[g] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    m_rr = 0;
    outstanding = 0;
    age = 0;
    exp_q.delete();
    #20;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run8(input string tag, input logic [W8-1:0] d, input logic [S-1:0] s,
                      input logic [W8-1:0] exp);
    @(posedge clk);
    #1;
    data8[W8-1:0] = d;
    sh8[S-1:0]    = s;
    v8            = 4'b0001;
    rr8           = 1'b1;
    @(negedge clk);
    chk({tag, "_ready"}, rdy8, 4'b0001);
    @(posedge clk);
    #1;
    v8 = '0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, rv8, 1'b1);
    chk({tag, "_data"}, d8, exp);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] bnd_dat;
    int  bnd_s[3];
    logic [W-1:0] bnd_e[3];
    int  n2;
    req_valid = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      dat[i] = '0;
      shf[i] = '0;
    end
    v8 = '0; data8 = '0; sh8 = '0; rr8 = 1'b1;
    m_rr = 0; outstanding = 0; age = 0; cyc = 0; hs_cyc = 0; cont = 1'b0;
    last_resp = '0; last_id = '0; last_rdy = '0; last_busy = 1'b0; last_rv = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_rr_ptr", dut.rr_ptr, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request
    dat[2] = 16'h00F3; shf[2] = 4'd4; req_valid = 4'b0100;
    cycle();
    chk("single_ready", last_rdy, 4'b0100);
    cycle();
    chk("single_t1_valid", last_rv, 0);
    cycle();
    chk("single_t2_valid", last_rv, 1);
    chk("single_data", last_resp, 16'h0F30);
    chk("single_id", last_id, 2);
    cycle();

    // All requesters continuously valid
    do_reset();
    cont = 1'b1;
    for (int i = 0; i < N; i++) begin
      dat[i] = W'($urandom);
      shf[i] = S'($urandom);
    end
    req_valid = 4'hF;
    glog.delete(); gcyc.delete();
    repeat (18) cycle();
    cont = 1'b0;
    req_valid = '0;
    cycle();
    chk("rr_count", glog.size(), 6);
    for (int i = 0; i < glog.size() && i < 6; i++) chk("rr_order", glog[i], i % N);
    for (int i = 1; i < gcyc.size() && i < 6; i++) chk("rr_gap", gcyc[i] - gcyc[i-1], 3);

    // Backpressure with a second requester waiting
    do_reset();
    resp_ready = 1'b0;
    dat[0] = 16'h1234; shf[0] = 4'd3; req_valid = 4'b0001;
    cycle();
    dat[1] = 16'h00AB; shf[1] = 4'd2; req_valid[1] = 1'b1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_busy", last_busy, 1);
      chk("bp_ready", last_rdy, 0);
      chk("bp_data", last_resp, 16'h91A0);
      chk("bp_id", last_id, 0);
    end
    resp_ready = 1'b1;
    cycle();
    cycle();
    chk("bp_next_grant", glog[$], 1);
    chk("bp_grant_cycle", gcyc[$], hs_cyc + 1);
    repeat (3) cycle();

    // Boundary shift amounts
    bnd_dat = 16'h8001;
    bnd_s = '{0, 15, 1};
    bnd_e = '{16'h8001, 16'h8000, 16'h0002};
    for (int i = 0; i < 3; i++) begin
      dat[0] = bnd_dat; shf[0] = S'(bnd_s[i]); req_valid = 4'b0001;
      repeat (3) cycle();
      chk("bnd_shift", last_resp, bnd_e[i]);
    end
    cycle();

    // Narrow instance: shift beyond the width clears the result
    run8("w8_over", 8'hFF, 4'd9, 8'h00);
    run8("w8_norm", 8'hFF, 4'd3, 8'hF8);

    // Reset dropped while a request is executing
    do_reset();
    dat[2] = 16'h0055; shf[2] = 4'd1; req_valid = 4'b0100;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rr_ptr", dut.rr_ptr, 0);
    m_rr = 0; outstanding = 0; age = 0; exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_no_resp", resp_valid, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dat[0] = 16'h0003; shf[0] = 4'd2;
    dat[3] = 16'h0700; shf[3] = 4'd4;
    req_valid = 4'b1001;
    cycle();
    chk("post_rst_grant", last_rdy, 4'b0001);
    repeat (6) cycle();

    // Pointer wrap, skip, and a withdrawn request
    do_reset();
    glog.delete();
    dat[3] = 16'h0101; shf[3] = 4'd5; req_valid = 4'b1000;
    cycle();
    dat[2] = 16'hBEEF; shf[2] = 4'd1; req_valid[2] = 1'b1;
    cycle();
    req_valid[2] = 1'b0;
    cycle();
    dat[1] = 16'h4001; shf[1] = 4'd1; req_valid = 4'b0010;
    cycle();
    chk("wrap_grant", last_rdy, 4'b0010);
    chk("wrap_rr_ptr", dut.rr_ptr, 2);
    repeat (3) cycle();
    n2 = 0;
    foreach (glog[i]) if (glog[i] == 2) n2++;
    chk("withdrawn_not_served", n2, 0);

    // Randomized traffic with random backpressure and occasional withdrawal
    do_reset();
    glog.delete();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          dat[i] = W'($urandom);
          shf[i] = S'($urandom);
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    req_valid = '0;
    resp_ready = 1'b1;
    repeat (4) cycle();
    chk("rand_activity", glog.size() > 20, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
